// File: rtl/vrased_rst_pkg.sv
// Shared types and defaults for the VRASED reset sequencer.
package vrased_rst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitVec,
        StAck
    } seq_state_e;

    localparam logic [15:0] DefResetHandler = 16'hFFFE;
    localparam int unsigned DefHoldCycles   = 16;
    localparam int unsigned DefVecTimeout   = 64;

    localparam int unsigned CauseViol1 = 0;
    localparam int unsigned CauseViol2 = 1;
    localparam int unsigned CauseViol3 = 2;

    // Width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter shared by the HOLD and WAIT_VEC windows.
module rst_seq_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vrased_reset_seq.sv
// Reset sequencer: holds the core in reset, waits for the reset vector, then acknowledges.
module vrased_reset_seq
    import vrased_rst_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
    parameter int unsigned VEC_TIMEOUT   = DefVecTimeout,
    parameter logic [15:0] RESET_HANDLER = DefResetHandler,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             kill_req,
    input  logic [2:0]       viol_cause,
    input  logic [15:0]      pc,
    output logic             cpu_rst,
    output logic             kill_ack,
    output logic             seq_busy,
    output logic [2:0]       last_cause,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [3:0]       retry_cnt
);

    localparam int unsigned   TW       = timer_width(HOLD_CYCLES, VEC_TIMEOUT);
    localparam logic [TW-1:0] HoldLoad = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] VecLoad  = TW'(VEC_TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic          start;
    logic          retry;
    logic          t_load;
    logic          t_dec;
    logic [TW-1:0] t_val;
    logic          t_zero;

    rst_seq_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (t_load),
        .load_val(t_val),
        .dec     (t_dec),
        .zero    (t_zero)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        retry   = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = HoldLoad;
        unique case (state_q)
            StIdle: begin
                if (kill_req) begin
                    state_d = StHold;
                    start   = 1'b1;
                    t_load  = 1'b1;
                end
            end
            StHold: begin
                if (t_zero) begin
                    state_d = StWaitVec;
                    t_load  = 1'b1;
                    t_val   = VecLoad;
                end else begin
                    t_dec = 1'b1;
                end
            end
            StWaitVec: begin
                // Vector match wins over a timeout on the same cycle.
                if (pc == RESET_HANDLER) begin
                    state_d = StAck;
                end else if (t_zero) begin
                    state_d = StHold;
                    retry   = 1'b1;
                    t_load  = 1'b1;
                end else begin
                    t_dec = 1'b1;
                end
            end
            StAck: begin
                if (kill_req) begin
                    state_d = StHold;
                    start   = 1'b1;
                    t_load  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cpu_rst    <= 1'b0;
            kill_ack   <= 1'b0;
            seq_busy   <= 1'b0;
            last_cause <= '0;
            viol_cnt   <= '0;
            retry_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            cpu_rst  <= (state_d == StHold);
            kill_ack <= (state_d == StAck);
            seq_busy <= (state_d != StIdle);
            if (start) begin
                last_cause <= viol_cause;
                retry_cnt  <= '0;
                if (viol_cnt != '1) begin
                    viol_cnt <= viol_cnt + 1'b1;
                end
            end else begin
                if ((state_q == StHold) && kill_req) begin
                    last_cause <= last_cause | viol_cause;
                end
                if (retry && (retry_cnt != 4'hF)) begin
                    retry_cnt <= retry_cnt + 1'b1;
                end
            end
        end
    end

endmodule
